// File: rtl/if_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_fetch_pkg;

    typedef enum logic [0:0] {
        StIssue,
        StHold
    } state_e;

    localparam logic [31:0]  ZeroWord           = 32'h0000_0000;
    localparam logic [31:0]  ResetPcDefault     = 32'h0000_0000;
    localparam int unsigned  IcacheLinesDefault = 64;

endpackage

// File: rtl/if_icache.sv
// Direct-mapped instruction cache: combinational lookup, single fill port.
// Valid bits are cleared only by reset.
module if_icache #(
    parameter int unsigned Lines = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lookup_pc_i,
    output logic        hit_o,
    output logic [31:0] data_o,
    input  logic        fill_en_i,
    input  logic [31:0] fill_pc_i,
    input  logic [31:0] fill_data_i
);

    localparam int unsigned IdxW = $clog2(Lines);
    localparam int unsigned TagW = 32 - IdxW;

    logic [Lines-1:0] valid_q;
    logic [TagW-1:0]  tag_q  [Lines];
    logic [31:0]      data_q [Lines];

    logic [IdxW-1:0] rd_idx, wr_idx;
    logic [TagW-1:0] rd_tag, wr_tag;

    // pc[1:0] joins the tag so unaligned targets never alias an aligned word.
    assign rd_idx = lookup_pc_i[IdxW+1:2];
    assign rd_tag = {lookup_pc_i[31:IdxW+2], lookup_pc_i[1:0]};
    assign wr_idx = fill_pc_i[IdxW+1:2];
    assign wr_tag = {fill_pc_i[31:IdxW+2], fill_pc_i[1:0]};

    assign hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign data_o = data_q[rd_idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= fill_data_i;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a little-endian word from four byte reads and holds it for
// decode. Optional direct-mapped I-cache enabled by defining ICACHE_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = ResetPcDefault,
    parameter int unsigned ICACHE_LINES = IcacheLinesDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        mem_grant_in,
    input  logic [7:0]  mem_byte_in,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid_out
);

    if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of two >= 2");
    end

    state_e      state_q;
    logic [31:0] pc_q;
    logic [2:0]  issue_q;
    logic [1:0]  recv_q;
    logic        pend_q;
    logic [23:0] buf_q;
    logic [31:0] pc_out_q;
    logic [31:0] inst_q;
    logic        valid_q;

    logic        entry;
    logic        use_hit;
    logic [31:0] hit_data;
    logic        req;
    logic        last_byte;

    // First cycle of a fresh fetch: nothing issued or outstanding yet.
    assign entry     = (state_q == StIssue) && (issue_q == 3'd0) && (recv_q == 2'd0) && !pend_q;
    assign last_byte = (state_q == StIssue) && pend_q && (recv_q == 2'd3);
    assign req       = rst && (state_q == StIssue) && (issue_q < 3'd4) && !use_hit;

`ifdef ICACHE_EN
    logic hit;
    logic fill_en;

    // A redirect in the completing cycle aborts the fetch, so it must not fill.
    assign fill_en = last_byte && !branch_taken_in;
    assign use_hit = entry && hit;

    if_icache #(
        .Lines(ICACHE_LINES)
    ) u_icache (
        .clk_i      (clk),
        .rst_ni     (rst),
        .lookup_pc_i(pc_q),
        .hit_o      (hit),
        .data_o     (hit_data),
        .fill_en_i  (fill_en),
        .fill_pc_i  (pc_q),
        .fill_data_i({mem_byte_in, buf_q})
    );
`else
    assign use_hit  = 1'b0;
    assign hit_data = ZeroWord;
`endif

    assign mem_req_out    = req;
    assign mem_addr_out   = req ? (pc_q + {29'b0, issue_q}) : ZeroWord;
    assign pc_out         = pc_out_q;
    assign inst_out       = inst_q;
    assign inst_valid_out = valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIssue;
            pc_q     <= RESET_PC;
            issue_q  <= 3'd0;
            recv_q   <= 2'd0;
            pend_q   <= 1'b0;
            buf_q    <= '0;
            pc_out_q <= ZeroWord;
            inst_q   <= ZeroWord;
            valid_q  <= 1'b0;
        end else if (branch_taken_in) begin
            state_q <= StIssue;
            pc_q    <= branch_target_in;
            issue_q <= 3'd0;
            recv_q  <= 2'd0;
            pend_q  <= 1'b0;
            inst_q  <= ZeroWord;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIssue: begin
                    pend_q <= req && mem_grant_in;
                    if (req && mem_grant_in) begin
                        issue_q <= issue_q + 3'd1;
                    end
                    if (use_hit) begin
                        inst_q   <= hit_data;
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                        state_q  <= StHold;
                    end else if (last_byte) begin
                        inst_q   <= {mem_byte_in, buf_q};
                        pc_out_q <= pc_q;
                        valid_q  <= 1'b1;
                        recv_q   <= 2'd0;
                        state_q  <= StHold;
                    end else if (pend_q) begin
                        // Shift in from the top: after three bytes buf_q = {b2, b1, b0}.
                        buf_q  <= {mem_byte_in, buf_q[23:8]};
                        recv_q <= recv_q + 2'd1;
                    end
                end
                StHold: begin
                    if (!stall_in) begin
                        pc_q    <= pc_q + 32'd4;
                        issue_q <= 3'd0;
                        recv_q  <= 2'd0;
                        pend_q  <= 1'b0;
                        inst_q  <= ZeroWord;
                        valid_q <= 1'b0;
                        state_q <= StIssue;
                    end
                end
                default: state_q <= StIssue;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte assembly, stall, grant gaps, redirect, pc wrap, reset.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_in = 1'b1;
    logic        branch_taken_in = 1'b0;
    logic [31:0] branch_target_in = 32'h0;
    logic        mem_grant_in = 1'b1;
    logic [7:0]  mem_byte_in = 8'h00;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid_out;

    logic [7:0]  mem [0:511];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    logic        last_req;
    logic        acc;
    logic [31:0] last_addr;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall_in        (stall_in),
        .branch_taken_in (branch_taken_in),
        .branch_target_in(branch_target_in),
        .mem_grant_in    (mem_grant_in),
        .mem_byte_in     (mem_byte_in),
        .mem_req_out     (mem_req_out),
        .mem_addr_out    (mem_addr_out),
        .pc_out          (pc_out),
        .inst_out        (inst_out),
        .inst_valid_out  (inst_valid_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge with inputs set; samples the request, then returns at the
    // next negedge having driven the read byte for an accepted request.
    task automatic cyc();
        #1;
        last_req  = mem_req_out;
        last_addr = mem_addr_out;
        acc       = mem_req_out & mem_grant_in;
        @(negedge clk);
        mem_byte_in = acc ? mem[last_addr[8:0]] : 8'hEE;
    endtask

    task automatic fetch4(input logic [31:0] base, input logic [31:0] word);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_eq("req", 32'(last_req), 32'd1);
            check_eq("addr", last_addr, base + 32'(i));
            check_eq("busy_valid", 32'(inst_valid_out), 32'd0);
        end
        cyc();
        check_eq("done_req", 32'(last_req), 32'd0);
        check_eq("done_valid", 32'(inst_valid_out), 32'd1);
        check_eq("done_inst", inst_out, word);
        check_eq("done_pc", pc_out, base);
    endtask

    task automatic redirect(input logic [31:0] target);
        branch_taken_in  = 1'b1;
        branch_target_in = target;
        cyc();
        branch_taken_in = 1'b0;
        check_eq("redir_valid", 32'(inst_valid_out), 32'd0);
        check_eq("redir_inst", inst_out, 32'h0);
    endtask

    task automatic leave_hold();
        stall_in = 1'b0;
        cyc();
        stall_in = 1'b1;
        check_eq("release_valid", 32'(inst_valid_out), 32'd0);
        check_eq("release_inst", inst_out, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
        mem[0]   = 8'h13; mem[1]   = 8'h05; mem[2]   = 8'h10; mem[3]   = 8'h00;
        mem[4]   = 8'h93; mem[5]   = 8'h00; mem[6]   = 8'h00; mem[7]   = 8'h00;
        mem[8]   = 8'h13; mem[9]   = 8'h01; mem[10]  = 8'hF0; mem[11]  = 8'hFF;
        mem[16]  = 8'h6F; mem[17]  = 8'h00; mem[18]  = 8'h00; mem[19]  = 8'h00;
        mem[256] = 8'hB3; mem[257] = 8'h00; mem[258] = 8'h20; mem[259] = 8'h00;

        #1;
        check_eq("rst_req", 32'(mem_req_out), 32'd0);
        check_eq("rst_addr", mem_addr_out, 32'h0);
        check_eq("rst_pc", pc_out, 32'h0);
        check_eq("rst_inst", inst_out, 32'h0);
        check_eq("rst_valid", 32'(inst_valid_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic fetch from RESET_PC.
        fetch4(32'h0, 32'h0010_0513);

        // Stall holds everything.
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("stall_valid", 32'(inst_valid_out), 32'd1);
            check_eq("stall_inst", inst_out, 32'h0010_0513);
            check_eq("stall_pc", pc_out, 32'h0);
            check_eq("stall_req", 32'(last_req), 32'd0);
        end
        leave_hold();
        fetch4(32'h4, 32'h0000_0093);

        // Grant dropped for two cycles after the first accepted byte.
        leave_hold();
        cyc();
        check_eq("gap_addr0", last_addr, 32'h8);
        mem_grant_in = 1'b0;
        cyc();
        check_eq("gap_req", 32'(last_req), 32'd1);
        check_eq("gap_addr1", last_addr, 32'h9);
        cyc();
        check_eq("gap_addr2", last_addr, 32'h9);
        mem_grant_in = 1'b1;
        for (int i = 1; i < 4; i++) begin
            cyc();
            check_eq("gap_addr", last_addr, 32'h8 + 32'(i));
        end
        check_eq("gap_late_valid", 32'(inst_valid_out), 32'd0);
        cyc();
        check_eq("gap_valid", 32'(inst_valid_out), 32'd1);
        check_eq("gap_inst", inst_out, 32'hFFF0_0113);
        check_eq("gap_pc", pc_out, 32'h8);

        // Redirect on the third byte cycle; the returning byte must be dropped.
        leave_hold();
        cyc();
        check_eq("br_addr0", last_addr, 32'hC);
        cyc();
        redirect(32'h100);
        check_eq("br_addr2", last_addr, 32'hE);
        fetch4(32'h100, 32'h0020_00B3);

        // Redirect wins over stall in HOLD.
        redirect(32'h10);
        fetch4(32'h10, 32'h0000_006F);

        // PC increment wraps to zero.
        redirect(32'hFFFF_FFFC);
        fetch4(32'hFFFF_FFFC, 32'hFFFF_FFFF);
        leave_hold();
`ifdef ICACHE_EN
        cyc();
        check_eq("wrap_hit_req", 32'(last_req), 32'd0);
        check_eq("wrap_hit_valid", 32'(inst_valid_out), 32'd1);
        check_eq("wrap_hit_inst", inst_out, 32'h0010_0513);
        check_eq("wrap_hit_pc", pc_out, 32'h0);
`else
        fetch4(32'h0, 32'h0010_0513);
`endif

        // Reset mid-fetch discards partial bytes.
        redirect(32'h20);
        cyc();
        cyc();
        check_eq("pre_rst_addr", last_addr, 32'h21);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_req", 32'(mem_req_out), 32'd0);
        check_eq("mid_rst_addr", mem_addr_out, 32'h0);
        check_eq("mid_rst_pc", pc_out, 32'h0);
        check_eq("mid_rst_inst", inst_out, 32'h0);
        check_eq("mid_rst_valid", 32'(inst_valid_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        fetch4(32'h0, 32'h0010_0513);

        // Second fetch of 0x0: cache hit delivers on entry with no memory request.
        redirect(32'h0);
`ifdef ICACHE_EN
        cyc();
        check_eq("hit_req", 32'(last_req), 32'd0);
        check_eq("hit_valid", 32'(inst_valid_out), 32'd1);
        check_eq("hit_inst", inst_out, 32'h0010_0513);
        check_eq("hit_pc", pc_out, 32'h0);
`else
        fetch4(32'h0, 32'h0010_0513);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
